// File: rtl/backdoor_pkg.sv
// Shared opcode and state encodings for the backdoor access port initiator.
package backdoor_pkg;

  typedef enum logic [31:0] {
    NOP    = 32'd0,
    WR_REG = 32'd1,
    RD_REG = 32'd2,
    WR_MEM = 32'd3,
    RD_MEM = 32'd4
  } bd_op_e;

  localparam logic [31:0] IDLE_SIG = 32'hdeadbeef;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_RESP,
    DONE,
    ERR
  } bd_state_e;

  function automatic logic is_write_op(input logic [31:0] op);
    return (op == WR_REG) || (op == WR_MEM);
  endfunction

  function automatic logic is_read_op(input logic [31:0] op);
    return (op == RD_REG) || (op == RD_MEM);
  endfunction

endpackage

// File: rtl/backdoor_driver.sv
// Sequences host transactions into word-by-word backdoor commands and
// returns read data from the combinational backdoor responder.
module backdoor_driver
  import backdoor_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_op,
  input  logic [31:0]   req_id,
  input  logic [31:0]   req_mask,
  input  logic [CW-1:0] req_count,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [31:0]   wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic          rd_last,
  output logic          done,
  output logic          err,
  output logic          link_ok,
  output logic [31:0]   acc_opcode,
  output logic [31:0]   acc_id,
  output logic [31:0]   acc_mask,
  output logic [31:0]   acc_in,
  input  logic [31:0]   acc_out
);

  bd_state_e     state_q, state_d;
  logic [31:0]   op_q, op_d, id_q, id_d, base_q, base_d;
  logic [CW-1:0] count_q, count_d, idx_q, idx_d;
  logic [31:0]   acc_opcode_q, acc_opcode_d, acc_id_q, acc_id_d;
  logic [31:0]   acc_mask_q, acc_mask_d, acc_in_q, acc_in_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          link_ok_q, link_ok_d;
  logic          last_word, req_ok;

  assign last_word = (idx_q == count_q - CW'(1));
  assign req_ok    = (is_write_op(req_op) || is_read_op(req_op)) &&
                     (req_count != '0) && (req_count <= CW'(MAX_WORDS));

  // Command registers default to nop; only a beat or a read issue loads them.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    id_d         = id_q;
    base_d       = base_q;
    count_d      = count_q;
    idx_d        = idx_q;
    acc_opcode_d = NOP;
    acc_id_d     = '0;
    acc_mask_d   = '0;
    acc_in_d     = '0;
    rd_data_d    = rd_data_q;
    link_ok_d    = link_ok_q;
    unique case (state_q)
      IDLE: begin
        link_ok_d = (acc_out == IDLE_SIG);
        if (req_valid) begin
          op_d    = req_op;
          id_d    = req_id;
          base_d  = req_mask;
          count_d = req_count;
          idx_d   = '0;
          if (!req_ok) begin
            state_d = ERR;
          end else if (is_write_op(req_op)) begin
            state_d = WRITE;
          end else begin
            state_d      = RD_ISSUE;
            acc_opcode_d = req_op;
            acc_id_d     = req_id;
            acc_mask_d   = req_mask;
          end
        end
      end
      WRITE: begin
        if (wr_valid) begin
          acc_opcode_d = op_q;
          acc_id_d     = id_q;
          acc_mask_d   = base_q + 32'(idx_q);
          acc_in_d     = wr_data;
          idx_d        = idx_q + CW'(1);
          if (last_word) state_d = DONE;
        end
      end
      RD_ISSUE: begin
        rd_data_d = acc_out;
        state_d   = RD_RESP;
      end
      RD_RESP: begin
        if (rd_ready) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            idx_d        = idx_q + CW'(1);
            state_d      = RD_ISSUE;
            acc_opcode_d = op_q;
            acc_id_d     = id_q;
            acc_mask_d   = base_q + 32'(idx_q) + 32'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_opcode_q <= '0;
      acc_id_q     <= '0;
      acc_mask_q   <= '0;
      acc_in_q     <= '0;
      rd_data_q    <= '0;
      link_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_opcode_q <= acc_opcode_d;
      acc_id_q     <= acc_id_d;
      acc_mask_q   <= acc_mask_d;
      acc_in_q     <= acc_in_d;
      rd_data_q    <= rd_data_d;
      link_ok_q    <= link_ok_d;
    end
  end

  // Transaction context is always reloaded on acceptance, so it needs no reset.
  always_ff @(posedge clock) begin
    op_q    <= op_d;
    id_q    <= id_d;
    base_q  <= base_d;
    count_q <= count_d;
    idx_q   <= idx_d;
  end

  assign req_ready  = (state_q == IDLE);
  assign wr_ready   = (state_q == WRITE);
  assign rd_valid   = (state_q == RD_RESP);
  assign rd_last    = rd_valid && last_word;
  assign rd_data    = rd_data_q;
  assign done       = (state_q == DONE) || (state_q == ERR);
  assign err        = (state_q == ERR);
  assign link_ok    = link_ok_q;
  assign acc_opcode = acc_opcode_q;
  assign acc_id     = acc_id_q;
  assign acc_mask   = acc_mask_q;
  assign acc_in     = acc_in_q;

endmodule

// File: tb/tb_backdoor_driver.sv
// Self-checking bench for backdoor_driver with a behavioural responder and
// per-cycle expectations derived from the transaction rules.
module tb_backdoor_driver;
  import backdoor_pkg::*;

  localparam int MW = 16;
  localparam int CW = $clog2(MW + 1);

  logic          clock, reset;
  logic          req_valid, req_ready;
  logic [31:0]   req_op, req_id, req_mask;
  logic [CW-1:0] req_count;
  logic          wr_valid, wr_ready;
  logic [31:0]   wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [31:0]   rd_data;
  logic          done, err, link_ok;
  logic [31:0]   acc_opcode, acc_id, acc_mask, acc_in, acc_out;
  logic [31:0]   idle_word;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  backdoor_driver #(.MAX_WORDS(MW), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_id(req_id), .req_mask(req_mask), .req_count(req_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err), .link_ok(link_ok),
    .acc_opcode(acc_opcode), .acc_id(acc_id), .acc_mask(acc_mask),
    .acc_in(acc_in), .acc_out(acc_out)
  );

  // Responder: idle signature on nop, mask*0x11 for reads, zero for writes.
  assign acc_out = (acc_opcode == 32'd0) ? idle_word :
                   ((acc_opcode == 32'd2) || (acc_opcode == 32'd4)) ? acc_mask * 32'h11 :
                   32'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  function automatic int stall_len(input int mode, input int i);
    if (mode == 1) return int'($urandom_range(0, 2));
    if (mode == 2) return (i == 1) ? 2 : 0;
    return 0;
  endfunction

  task automatic run_txn(input logic [31:0] op, input logic [31:0] id,
                         input logic [31:0] base, input int count, input int mode);
    bit          legal, is_wr;
    logic [31:0] wd, m, exp_rd;
    int          k;
    legal = (op >= 32'd1) && (op <= 32'd4) && (count >= 1) && (count <= MW);
    is_wr = (op == 32'd1) || (op == 32'd3);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_id = id; req_mask = base; req_count = CW'(count);
    cyc();
    req_valid = 1'b0; req_op = $urandom; req_id = $urandom; req_mask = $urandom;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (!legal) begin
      chk("err_done", 32'(done), 32'd1);
      chk("err_flag", 32'(err), 32'd1);
      chk("err_nop", acc_opcode, 32'd0);
    end else if (is_wr) begin
      for (int i = 0; i < count; i++) begin
        k = stall_len(mode, i);
        repeat (k) begin
          wr_valid = 1'b0; wr_data = $urandom;
          cyc();
          chk("wr_gap_nop", acc_opcode, 32'd0);
          chk("wr_gap_done", 32'(done), 32'd0);
        end
        wd = $urandom;
        wr_valid = 1'b1; wr_data = wd;
        chk("wr_ready", 32'(wr_ready), 32'd1);
        cyc();
        m = base + 32'(i);
        chk("wr_opcode", acc_opcode, op);
        chk("wr_id", acc_id, id);
        chk("wr_mask", acc_mask, m);
        chk("wr_in", acc_in, wd);
        chk("wr_done", 32'(done), (i == count - 1) ? 32'd1 : 32'd0);
        chk("wr_err", 32'(err), 32'd0);
      end
      wr_valid = 1'b0; wr_data = $urandom;
    end else begin
      for (int i = 0; i < count; i++) begin
        m = base + 32'(i);
        exp_rd = m * 32'h11;
        chk("rd_opcode", acc_opcode, op);
        chk("rd_id", acc_id, id);
        chk("rd_mask", acc_mask, m);
        chk("rd_in", acc_in, 32'd0);
        chk("rd_valid_issue", 32'(rd_valid), 32'd0);
        cyc();
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_data", rd_data, exp_rd);
        chk("rd_last", 32'(rd_last), (i == count - 1) ? 32'd1 : 32'd0);
        chk("rd_resp_nop", acc_opcode, 32'd0);
        k = stall_len(mode, i);
        repeat (k) begin
          rd_ready = 1'b0;
          cyc();
          chk("rd_hold_valid", 32'(rd_valid), 32'd1);
          chk("rd_hold_data", rd_data, exp_rd);
          chk("rd_hold_nop", acc_opcode, 32'd0);
        end
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("rd_done", 32'(done), (i == count - 1) ? 32'd1 : 32'd0);
        chk("rd_valid_after", 32'(rd_valid), 32'd0);
      end
      chk("rd_err", 32'(err), 32'd0);
    end
    cyc();
    chk("end_done", 32'(done), 32'd0);
    chk("end_nop", acc_opcode, 32'd0);
    chk("end_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r_op, r_base;
    int          r_cnt;
    reset = 1'b1; idle_word = IDLE_SIG;
    req_valid = 1'b0; req_op = '0; req_id = '0; req_mask = '0; req_count = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (2) cyc();
    chk("rst_opcode", acc_opcode, 32'd0);
    chk("rst_id", acc_id, 32'd0);
    chk("rst_mask", acc_mask, 32'd0);
    chk("rst_in", acc_in, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_link_ok", 32'(link_ok), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    cyc();
    chk("link_ok_sig", 32'(link_ok), 32'd1);
    idle_word = 32'h12345678;
    cyc();
    chk("link_ok_nosig", 32'(link_ok), 32'd0);
    idle_word = IDLE_SIG;
    cyc();
    chk("link_ok_back", 32'(link_ok), 32'd1);

    run_txn(32'd1, 32'd1, 32'd0, 1, 0);
    run_txn(32'd4, 32'd2, 32'd4, 3, 2);
    run_txn(32'd7, 32'd3, 32'd0, 2, 0);
    run_txn(32'd0, 32'd3, 32'd0, 2, 0);
    run_txn(32'd1, 32'd3, 32'd0, 0, 0);
    run_txn(32'd2, 32'd3, 32'd0, MW + 1, 0);
    run_txn(32'd3, 32'd5, 32'hFFFFFFFF, 2, 1);
    run_txn(32'd2, 32'd5, 32'hFFFFFFFF, 2, 0);
    run_txn(32'd3, 32'd6, 32'd100, MW, 0);

    // Reset while a read response is pending.
    req_valid = 1'b1; req_op = 32'd2; req_id = 32'd8; req_mask = 32'd8; req_count = CW'(2);
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("mid_rd_valid", 32'(rd_valid), 32'd1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_nop", acc_opcode, 32'd0);
    reset = 1'b0;
    cyc();
    chk("post_rst_done", 32'(done), 32'd0);
    run_txn(32'd4, 32'd9, 32'd100, 2, 1);

    for (int t = 0; t < 40; t++) begin
      r_op   = 32'($urandom_range(0, 5));
      r_cnt  = int'($urandom_range(0, MW + 2));
      r_base = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 4))) : $urandom;
      run_txn(r_op, $urandom, r_base, r_cnt, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
